account_txn_arbiter: RTL and testbench

Sequencer and arbiter for the shared accounts RAM. Accepts account transactions (balance read, withdraw, deposit, password change, deactivate) from two requesters: port 0 is the ATM control unit, port 1 is the bank host. It grants one requester round-robin and runs a fixed-latency read-modify-write on the single-port RAM. It returns a status and the resulting balance, so no other block writes the accounts RAM directly.

---
 rtl/atm_txn_pkg.sv | 38 +++
 rtl/rr_arbiter2.sv | 26 ++
 rtl/account_txn_arbiter.sv | 171 +++++++++++++++++
 tb/tb_account_txn_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/atm_txn_pkg.sv
// Shared types for the accounts-RAM transaction sequencer: opcodes, result codes,
// FSM states and the bit layout of a RAM word {password, balance, active}.
package atm_txn_pkg;

    typedef enum logic [2:0] {
        OP_READ       = 3'd0,
        OP_WITHDRAW   = 3'd1,
        OP_DEPOSIT    = 3'd2,
        OP_SET_PWD    = 3'd3,
        OP_DEACTIVATE = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        ST_OK           = 3'd0,
        ST_INSUFFICIENT = 3'd1,
        ST_INACTIVE     = 3'd2,
        ST_OVERFLOW     = 3'd3,
        ST_BAD_ADDR     = 3'd4,
        ST_BAD_OP       = 3'd5
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WT   = 2'd2,
        S_EX   = 2'd3
    } state_e;

    // Password sits above the balance, so its LSB moves with the balance width.
    localparam int ACTIVE_BIT = 0;
    localparam int BAL_LSB    = 1;
    localparam int PWD_LSB    = BAL_LSB + 16;

    function automatic int pwd_lsb(input int bal_width);
        return BAL_LSB + bal_width;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer names the port that wins a tie and
// flips away from whichever port was granted when the grant is taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = ptr ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ptr <= 1'b0;
        else if (take && |gnt)
            ptr <= gnt[0];
    end

endmodule

// File: rtl/account_txn_arbiter.sv
// Arbitrates two requesters onto the single-port accounts RAM and runs a fixed
// four-cycle read-modify-write per transaction (IDLE -> RD -> WT -> EX).
module account_txn_arbiter
    import atm_txn_pkg::*;
#(
    parameter int SAVED_ACCOUNTS       = 10,
    parameter int ACCOUNT_NUMBER_WIDTH = $clog2(SAVED_ACCOUNTS),
    parameter int PASSWORD_WIDTH       = 16,
    parameter int BALANCE_WIDTH        = 16,
    parameter int DATA_WIDTH           = (PASSWORD_WIDTH > BALANCE_WIDTH) ? PASSWORD_WIDTH : BALANCE_WIDTH,
    parameter int WORD_WIDTH           = PASSWORD_WIDTH + BALANCE_WIDTH + 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [1:0]                        req_valid,
    output logic [1:0]                        req_ready,
    input  logic [5:0]                        req_op,
    input  logic [2*ACCOUNT_NUMBER_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0]           req_data,
    output logic [1:0]                        rsp_valid,
    output logic [2:0]                        rsp_status,
    output logic [BALANCE_WIDTH-1:0]          rsp_balance,
    output logic                              busy,
    output logic [ACCOUNT_NUMBER_WIDTH-1:0]   ram_addr,
    output logic                              ram_rd_en,
    input  logic [WORD_WIDTH-1:0]             ram_rdata,
    output logic                              ram_wr_en,
    output logic [WORD_WIDTH-1:0]             ram_wdata
);

    localparam int AW      = ACCOUNT_NUMBER_WIDTH;
    localparam int BW      = BALANCE_WIDTH;
    localparam int PWD_POS = pwd_lsb(BALANCE_WIDTH);

    state_e state, state_nxt;

    logic [1:0]            gnt;
    logic                  accept;
    logic                  g_sel;
    logic                  lat_id;
    logic [2:0]            lat_op;
    logic [AW-1:0]         lat_addr;
    logic [DATA_WIDTH-1:0] lat_data;
    logic                  wr_pend;
    logic                  addr_ok;

    logic [BW-1:0]         cur_bal;
    logic [BW-1:0]         amt;
    logic [BW:0]           sum;
    logic                  active;
    logic [2:0]            x_status;
    logic [BW-1:0]         x_bal;
    logic [WORD_WIDTH-1:0] x_word;
    logic                  x_wr;

    rr_arbiter2 u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (req_valid),
        .take (state == S_IDLE),
        .gnt  (gnt)
    );

    assign accept    = (state == S_IDLE) && |gnt;
    assign g_sel     = gnt[1];
    assign req_ready = (state == S_IDLE) ? gnt : 2'b00;
    assign busy      = (state != S_IDLE);
    assign addr_ok   = 32'(lat_addr) < SAVED_ACCOUNTS;
    assign ram_addr  = lat_addr;
    // Out-of-range accounts never touch the RAM but still take the full four cycles.
    assign ram_rd_en = (state == S_RD) && addr_ok;
    assign ram_wr_en = (state == S_EX) && wr_pend;
    assign rsp_valid = (state == S_EX) ? (lat_id ? 2'b10 : 2'b01) : 2'b00;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RD;
            S_RD:    state_nxt = S_WT;
            S_WT:    state_nxt = S_EX;
            S_EX:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cur_bal  = ram_rdata[BAL_LSB +: BW];
        active   = ram_rdata[ACTIVE_BIT];
        amt      = lat_data[BW-1:0];
        sum      = {1'b0, cur_bal} + {1'b0, amt};
        x_status = ST_OK;
        x_bal    = cur_bal;
        x_word   = ram_rdata;
        x_wr     = 1'b0;
        if (!addr_ok) begin
            x_status = ST_BAD_ADDR;
            x_bal    = '0;
        end else begin
            case (lat_op)
                OP_READ: begin
                    if (!active) x_status = ST_INACTIVE;
                end
                OP_WITHDRAW: begin
                    if (!active)
                        x_status = ST_INACTIVE;
                    else if (amt > cur_bal)
                        x_status = ST_INSUFFICIENT;
                    else begin
                        x_bal                   = cur_bal - amt;
                        x_word[BAL_LSB +: BW]   = cur_bal - amt;
                        x_wr                    = 1'b1;
                    end
                end
                OP_DEPOSIT: begin
                    if (!active)
                        x_status = ST_INACTIVE;
                    else if (sum[BW])
                        x_status = ST_OVERFLOW;
                    else begin
                        x_bal                   = sum[BW-1:0];
                        x_word[BAL_LSB +: BW]   = sum[BW-1:0];
                        x_wr                    = 1'b1;
                    end
                end
                OP_SET_PWD: begin
                    if (!active)
                        x_status = ST_INACTIVE;
                    else begin
                        x_word[PWD_POS +: PASSWORD_WIDTH] = lat_data[PASSWORD_WIDTH-1:0];
                        x_wr                              = 1'b1;
                    end
                end
                OP_DEACTIVATE: begin
                    x_word[ACTIVE_BIT] = 1'b0;
                    x_wr               = 1'b1;
                end
                default: x_status = ST_BAD_OP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            lat_id      <= 1'b0;
            lat_op      <= '0;
            lat_addr    <= '0;
            lat_data    <= '0;
            wr_pend     <= 1'b0;
            rsp_status  <= '0;
            rsp_balance <= '0;
            ram_wdata   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_id   <= g_sel;
                lat_op   <= req_op[3*g_sel +: 3];
                lat_addr <= req_addr[AW*g_sel +: AW];
                lat_data <= req_data[DATA_WIDTH*g_sel +: DATA_WIDTH];
            end
            // Results land at the WT->EX edge so they line up with rsp_valid and then hold.
            if (state == S_WT) begin
                rsp_status  <= x_status;
                rsp_balance <= x_bal;
                ram_wdata   <= x_word;
                wr_pend     <= x_wr;
            end
        end
    end

endmodule

// File: tb/tb_account_txn_arbiter.sv
// Directed bench: behavioural RAM, a table of single-port transactions with
// hand-computed results, plus arbitration and mid-transaction reset sequences.
module tb_account_txn_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [5:0]  req_op = '0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  rsp_valid;
    logic [2:0]  rsp_status;
    logic [15:0] rsp_balance;
    logic        busy;
    logic [3:0]  ram_addr;
    logic        ram_rd_en;
    logic [32:0] ram_rdata = '0;
    logic        ram_wr_en;
    logic [32:0] ram_wdata;

    logic [32:0] mem [16];
    int n_wr = 0;
    int n_rd = 0;
    int n_cmp = 0;
    int n_err = 0;

    account_txn_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_status  (rsp_status),
        .rsp_balance (rsp_balance),
        .busy        (busy),
        .ram_addr    (ram_addr),
        .ram_rd_en   (ram_rd_en),
        .ram_rdata   (ram_rdata),
        .ram_wr_en   (ram_wr_en),
        .ram_wdata   (ram_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_rd_en) ram_rdata <= mem[ram_addr];
        if (ram_wr_en) mem[ram_addr] <= ram_wdata;
        if (ram_wr_en) n_wr <= n_wr + 1;
        if (ram_rd_en) n_rd <= n_rd + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int port, input logic [2:0] op, input logic [3:0] addr,
                           input logic [15:0] data, output logic [2:0] st, output logic [15:0] bal,
                           output int lat, output logic [1:0] rv, output int dwr, output int drd,
                           output logic [2:0] st_hold);
        int w0, r0, k;
        bit got;
        st = '1; bal = '1; lat = -1; rv = '0; dwr = -1; drd = -1; st_hold = '1;
        @(negedge clk);
        w0 = n_wr; r0 = n_rd;
        req_op[3*port +: 3]    = op;
        req_addr[4*port +: 4]  = addr;
        req_data[16*port +: 16] = data;
        req_valid[port]        = 1'b1;
        got = 0; k = 0;
        while (!got && k < 20) begin
            #1;
            if (req_ready[port]) got = 1;
            else begin @(negedge clk); k++; end
        end
        if (!got) begin
            req_valid = '0;
            return;
        end
        @(posedge clk);
        #1 req_valid[port] = 1'b0;
        got = 0; k = 0;
        while (!got && k < 10) begin
            @(negedge clk);
            k++;
            if (|rsp_valid) begin
                got = 1; lat = k; rv = rsp_valid; st = rsp_status; bal = rsp_balance;
            end
        end
        @(posedge clk);
        #1;
        dwr = n_wr - w0;
        drd = n_rd - r0;
        st_hold = rsp_status;
    endtask

    typedef struct {
        int          port;
        logic [2:0]  op;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [2:0]  st;
        logic [15:0] bal;
        int          wr;
        int          rd;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [2:0]  st, sh;
        logic [15:0] bal;
        logic [1:0]  rv;
        int          lat, dwr, drd, ng, cyc, w0;
        int          gport [4];
        int          gcyc [4];

        foreach (mem[i]) mem[i] = '0;
        mem[2] = {16'h1111, 16'd1000, 1'b1};
        mem[3] = {16'h1234, 16'd500, 1'b1};
        mem[5] = {16'h0000, 16'hFFFF, 1'b1};
        mem[7] = {16'hAAAA, 16'd100, 1'b0};

        //          port op    addr data     status bal      wr rd
        tbl[0]  = '{0, 3'd1, 4'd3,  16'd200,   3'd0, 16'd300,   1, 1};
        tbl[1]  = '{1, 3'd1, 4'd3,  16'd301,   3'd1, 16'd300,   0, 1};
        tbl[2]  = '{0, 3'd0, 4'd3,  16'd0,     3'd0, 16'd300,   0, 1};
        tbl[3]  = '{1, 3'd2, 4'd5,  16'd1,     3'd3, 16'hFFFF,  0, 1};
        tbl[4]  = '{0, 3'd1, 4'd5,  16'd1,     3'd0, 16'hFFFE,  1, 1};
        tbl[5]  = '{1, 3'd4, 4'd5,  16'd0,     3'd0, 16'hFFFE,  1, 1};
        tbl[6]  = '{0, 3'd1, 4'd5,  16'd1,     3'd2, 16'hFFFE,  0, 1};
        tbl[7]  = '{0, 3'd1, 4'd3,  16'd300,   3'd0, 16'd0,     1, 1};
        tbl[8]  = '{1, 3'd2, 4'd3,  16'd16,    3'd0, 16'd16,    1, 1};
        tbl[9]  = '{0, 3'd3, 4'd3,  16'hBEEF,  3'd0, 16'd16,    1, 1};
        tbl[10] = '{1, 3'd3, 4'd7,  16'h5555,  3'd2, 16'd100,   0, 1};
        tbl[11] = '{0, 3'd4, 4'd7,  16'd0,     3'd0, 16'd100,   1, 1};
        tbl[12] = '{1, 3'd0, 4'd12, 16'd0,     3'd4, 16'd0,     0, 0};
        tbl[13] = '{0, 3'd6, 4'd2,  16'd0,     3'd5, 16'd1000,  0, 1};
        tbl[14] = '{1, 3'd2, 4'd2,  16'd64535, 3'd0, 16'hFFFF,  1, 1};

        #3;
        chk("reset_outputs", 64'({req_ready, rsp_valid, rsp_status, rsp_balance, busy,
                                  ram_addr, ram_rd_en, ram_wr_en, ram_wdata}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Both ports hammer READs: grants must alternate from port 0, four cycles apart.
        @(negedge clk);
        req_op   = {3'd0, 3'd0};
        req_addr = {4'd2, 4'd3};
        req_valid = 2'b11;
        ng = 0; cyc = 0;
        while (ng < 4 && cyc < 40) begin
            #1;
            if (|req_ready) begin
                gport[ng] = req_ready[1] ? 1 : 0;
                gcyc[ng]  = cyc;
                ng++;
            end
            @(negedge clk);
            cyc++;
        end
        req_valid = '0;
        chk("rr_grant_count", 64'(ng), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant_port[%0d]", i), 64'(gport[i]), 64'(i % 2));
            if (i > 0) chk($sformatf("rr_spacing[%0d]", i), 64'(gcyc[i] - gcyc[i-1]), 64'd4);
        end
        cyc = 0;
        while (busy && cyc < 10) begin @(negedge clk); cyc++; end
        chk("rr_drain_idle", 64'(busy), 64'd0);

        for (int i = 0; i < 15; i++) begin
            run_txn(tbl[i].port, tbl[i].op, tbl[i].addr, tbl[i].data, st, bal, lat, rv, dwr, drd, sh);
            chk($sformatf("v%0d_status", i),  64'(st),  64'(tbl[i].st));
            chk($sformatf("v%0d_balance", i), 64'(bal), 64'(tbl[i].bal));
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd3);
            chk($sformatf("v%0d_rsp_port", i), 64'(rv), (tbl[i].port == 1) ? 64'd2 : 64'd1);
            chk($sformatf("v%0d_wr_count", i), 64'(dwr), 64'(tbl[i].wr));
            chk($sformatf("v%0d_rd_count", i), 64'(drd), 64'(tbl[i].rd));
            chk($sformatf("v%0d_status_hold", i), 64'(sh), 64'(tbl[i].st));
        end
        chk("mem3_pwd_bal", 64'(mem[3]), 64'({16'hBEEF, 16'd16, 1'b1}));
        chk("mem5_deact",   64'(mem[5]), 64'({16'h0000, 16'hFFFE, 1'b0}));
        chk("mem7_deact",   64'(mem[7]), 64'({16'hAAAA, 16'd100, 1'b0}));
        chk("mem2_deposit", 64'(mem[2]), 64'({16'h1111, 16'hFFFF, 1'b1}));

        // Reset lands while a WITHDRAW sits in WT: everything clears at once, nothing is written.
        @(negedge clk);
        w0 = n_wr;
        req_op[2:0] = 3'd1; req_addr[3:0] = 4'd2; req_data[15:0] = 16'd500;
        req_valid[0] = 1'b1;
        #1;
        chk("midrst_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = '0;
        @(posedge clk);
        #2;
        chk("midrst_in_wt_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        chk("midrst_outputs", 64'({req_ready, rsp_valid, rsp_status, rsp_balance, busy,
                                   ram_addr, ram_rd_en, ram_wr_en, ram_wdata}), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_write", 64'(n_wr - w0), 64'd0);
        chk("midrst_mem2", 64'(mem[2]), 64'({16'h1111, 16'hFFFF, 1'b1}));
        @(negedge clk);
        rst = 1'b1;
        run_txn(0, 3'd0, 4'd2, 16'd0, st, bal, lat, rv, dwr, drd, sh);
        chk("post_rst_read_status",  64'(st),  64'd0);
        chk("post_rst_read_balance", 64'(bal), 64'hFFFF);
        chk("post_rst_read_latency", 64'(lat), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
